// File: rtl/var_table_responder.sv
// var_table_responder
//   Memory-side responder for the variable-table access protocol. Holds a
//   small register-file table, serves one read or write per request with a
//   fixed latency, and zero-clears the whole table on initial_request.
module var_table_responder #(
  parameter int var_table_address_size = 3,
  parameter int data_width             = 8,
  parameter int read_latency           = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              mem_request,
  input  logic [var_table_address_size-1:0] var_table_address,
  input  logic                              mem_read,
  input  logic                              mem_write,
  input  logic [data_width-1:0]             write_data,
  input  logic                              initial_request,
  output logic [data_width-1:0]             var_table_output,
  output logic                              reg_write,
  output logic                              mem_finish,
  output logic                              initial_finish,
  output logic                              cmd_error,
  output logic                              busy
);

  localparam int AW    = var_table_address_size;
  localparam int DW    = data_width;
  localparam int DEPTH = 2 ** AW;
  localparam int LAT_W = $clog2(read_latency + 1);

  // WAIT runs read_latency-1 cycles, so the counter is loaded with that
  // value at accept and WAIT exits when it reaches one.
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(read_latency - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [AW-1:0]    CLR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;

  // Command captured at accept; inputs are ignored afterwards.
  logic [AW-1:0]     addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DW-1:0]     wdata_q, wdata_d;

  logic [DW-1:0]     rdata_q, rdata_d;
  logic [DW-1:0]     table_q [DEPTH];
  logic [DW-1:0]     table_d [DEPTH];

  // A command is legal only when exactly one of read/write is set.
  logic              in_is_read;
  logic              cmd_is_read;
  logic              cmd_is_write;

  assign in_is_read   = mem_read & ~mem_write;
  assign cmd_is_read  = rd_q & ~wr_q;
  assign cmd_is_write = wr_q & ~rd_q;

  // Next-state, datapath and completion pulses for the access FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    lat_cnt_d      = lat_cnt_q;
    clr_cnt_d      = clr_cnt_q;
    addr_d         = addr_q;
    rd_d           = rd_q;
    wr_d           = wr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    table_d        = table_q;
    mem_finish     = 1'b0;
    reg_write      = 1'b0;
    cmd_error      = 1'b0;
    initial_finish = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (initial_request) begin
          // Clearing has priority over a simultaneous access request.
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end else if (mem_request) begin
          addr_d    = var_table_address;
          rd_d      = mem_read;
          wr_d      = mem_write;
          wdata_d   = write_data;
          lat_cnt_d = LAT_LOAD;
          if (read_latency > 1) begin
            state_d = S_WAIT;
          end else begin
            // Single-cycle latency: read data is captured on the accept edge.
            state_d = S_DONE;
            if (in_is_read) begin
              rdata_d = table_q[var_table_address];
            end
          end
        end
      end

      S_WAIT: begin
        if (lat_cnt_q == LAT_ONE) begin
          state_d = S_DONE;
          // Read data is registered on the edge entering DONE.
          if (cmd_is_read) begin
            rdata_d = table_q[addr_q];
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_ONE;
        end
      end

      S_DONE: begin
        state_d    = S_IDLE;
        mem_finish = 1'b1;
        if (cmd_is_read) begin
          reg_write = 1'b1;
        end else if (cmd_is_write) begin
          // Committed on the edge leaving DONE.
          table_d[addr_q] = wdata_q;
        end else begin
          cmd_error = 1'b1;
        end
      end

      S_CLEAR: begin
        table_d[clr_cnt_q] = '0;
        clr_cnt_d          = clr_cnt_q + CLR_ONE;
        if (&clr_cnt_q) begin
          initial_finish = 1'b1;
          state_d        = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, captured command, read register and table storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lat_cnt_q <= '0;
      clr_cnt_q <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      // NOTE: the table is a flop array, not a RAM macro, so it can and
      // must be cleared by reset; the controller relies on all-zero words.
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples the
      // pre-edge value of every other flop.
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      clr_cnt_q <= clr_cnt_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= table_d[i];
      end
    end
  end

  assign var_table_output = rdata_q;
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_var_table_responder.sv
// Bench for var_table_responder: table-driven single accesses on a
// read_latency=2 instance, then hand-written clear, priority, reset and
// back-to-back sequences; a read_latency=1 instance covers short spacing.
module tb_var_table_responder;

  logic       clock;
  logic       reset;
  logic       mem_request;
  logic       mem_request1;
  logic [2:0] var_table_address;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] write_data;
  logic       initial_request;
  logic       initial_request1;

  logic [7:0] var_table_output,  var_table_output1;
  logic       reg_write,         reg_write1;
  logic       mem_finish,        mem_finish1;
  logic       initial_finish,    initial_finish1;
  logic       cmd_error,         cmd_error1;
  logic       busy,              busy1;

  var_table_responder #(
    .var_table_address_size(3), .data_width(8), .read_latency(2)
  ) dut (
    .clock(clock), .reset(reset), .mem_request(mem_request),
    .var_table_address(var_table_address), .mem_read(mem_read),
    .mem_write(mem_write), .write_data(write_data),
    .initial_request(initial_request), .var_table_output(var_table_output),
    .reg_write(reg_write), .mem_finish(mem_finish),
    .initial_finish(initial_finish), .cmd_error(cmd_error), .busy(busy)
  );

  var_table_responder #(
    .var_table_address_size(3), .data_width(8), .read_latency(1)
  ) dut1 (
    .clock(clock), .reset(reset), .mem_request(mem_request1),
    .var_table_address(var_table_address), .mem_read(mem_read),
    .mem_write(mem_write), .write_data(write_data),
    .initial_request(initial_request1), .var_table_output(var_table_output1),
    .reg_write(reg_write1), .mem_finish(mem_finish1),
    .initial_finish(initial_finish1), .cmd_error(cmd_error1), .busy(busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a command at a falling edge; it is accepted on the next rising edge.
  task automatic issue(input bit use1, input logic rd, input logic wr,
                       input logic [2:0] a, input logic [7:0] d);
    @(negedge clock);
    mem_read          = rd;
    mem_write         = wr;
    var_table_address = a;
    write_data        = d;
    if (use1) mem_request1 = 1'b1;
    else      mem_request  = 1'b1;
  endtask

  // Count falling edges until mem_finish is seen (bounded).
  task automatic wait_finish(input bit use1, output int n, output bit seen);
    n    = 0;
    seen = 0;
    do begin
      @(negedge clock);
      n++;
      seen = use1 ? mem_finish1 : mem_finish;
    end while (!seen && n < 20);
  endtask

  task automatic run_cmd(input bit use1, input logic rd, input logic wr,
                         input logic [2:0] a, input logic [7:0] d,
                         output int lat, output bit seen);
    issue(use1, rd, wr, a, d);
    wait_finish(use1, lat, seen);
    mem_request  = 1'b0;
    mem_request1 = 1'b0;
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp_out;
    logic       exp_rw;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, n;
    bit  seen, saw_fin;

    vecs[0] = '{1'b0, 1'b1, 3'd1, 8'hA5, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 3'd1, 8'h00, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 3'd3, 8'h3C, 8'hA5, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 3'd3, 8'h00, 8'h3C, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 3'd0, 8'h77, 8'h3C, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 3'd0, 8'h55, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 3'd7, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 3'd7, 8'h00, 8'hFF, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 3'd1, 8'h00, 8'hA5, 1'b1, 1'b0};

    reset             = 1'b0;
    mem_request       = 1'b0;
    mem_request1      = 1'b0;
    var_table_address = '0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    write_data        = '0;
    initial_request   = 1'b0;
    initial_request1  = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_finish", mem_finish, 0);
    check("rst_out", var_table_output, 8'h00);
    check("rst_flags", {reg_write, cmd_error, initial_finish}, 0);
    check("rst_busy1", busy1, 0);
    reset = 1'b1;

    // Table-driven single accesses, read_latency=2
    for (int i = 0; i < 10; i++) begin
      run_cmd(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, lat, seen);
      check($sformatf("vec%0d_seen", i), seen, 1);
      check($sformatf("vec%0d_lat", i), lat, 2);
      check($sformatf("vec%0d_out", i), var_table_output, vecs[i].exp_out);
      check($sformatf("vec%0d_rw", i), reg_write, vecs[i].exp_rw);
      check($sformatf("vec%0d_err", i), cmd_error, vecs[i].exp_err);
    end

    // Clear: preload all words, clear, a request raised mid-clear waits
    for (int a = 0; a < 8; a++) begin
      run_cmd(0, 1'b0, 1'b1, 3'(a), 8'hFF, lat, seen);
    end
    @(negedge clock);
    initial_request = 1'b1;
    n = 0;
    saw_fin = 0;
    do begin
      @(negedge clock);
      n++;
      if (mem_finish) saw_fin = 1;
      if (n == 3) begin
        mem_read          = 1'b1;
        mem_write         = 1'b0;
        var_table_address = 3'd5;
        mem_request       = 1'b1;
      end
    end while (!initial_finish && n < 20);
    check("clr_finish_cycle", n, 8);
    check("clr_busy", busy, 1);
    check("clr_out_kept", var_table_output, 8'hA5);
    check("clr_no_memfinish", saw_fin, 0);
    initial_request = 1'b0;
    wait_finish(0, lat, seen);
    mem_request = 1'b0;
    check("clr_req_lat", lat, 3);
    check("clr_req_out", var_table_output, 8'h00);
    check("clr_req_rw", reg_write, 1);
    for (int a = 0; a < 8; a++) begin
      run_cmd(0, 1'b1, 1'b0, 3'(a), 8'h00, lat, seen);
      check($sformatf("clr_rd%0d", a), var_table_output, 8'h00);
    end

    // Priority: clear and read raised together
    run_cmd(0, 1'b0, 1'b1, 3'd7, 8'h5A, lat, seen);
    @(negedge clock);
    initial_request   = 1'b1;
    mem_request       = 1'b1;
    mem_read          = 1'b1;
    mem_write         = 1'b0;
    var_table_address = 3'd7;
    n = 0;
    saw_fin = 0;
    do begin
      @(negedge clock);
      n++;
      if (mem_finish) saw_fin = 1;
    end while (!initial_finish && n < 20);
    check("prio_clear_cycle", n, 8);
    check("prio_no_memfinish", saw_fin, 0);
    initial_request = 1'b0;
    wait_finish(0, lat, seen);
    mem_request = 1'b0;
    check("prio_read_lat", lat, 3);
    check("prio_read_out", var_table_output, 8'h00);

    // Reset during WAIT of a write to addr 2
    issue(0, 1'b0, 1'b1, 3'd2, 8'h99);
    @(negedge clock);
    check("rstmid_busy_wait", busy, 1);
    reset = 1'b0;
    #1;
    check("rstmid_busy_low", busy, 0);
    mem_request = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    saw_fin = 0;
    repeat (3) begin
      @(negedge clock);
      if (mem_finish || busy) saw_fin = 1;
    end
    check("rstmid_quiet", saw_fin, 0);
    run_cmd(0, 1'b1, 1'b0, 3'd2, 8'h00, lat, seen);
    check("rstmid_tbl2", var_table_output, 8'h00);

    // Back-to-back reads, read_latency=2
    run_cmd(0, 1'b0, 1'b1, 3'd0, 8'h11, lat, seen);
    run_cmd(0, 1'b0, 1'b1, 3'd1, 8'h22, lat, seen);
    issue(0, 1'b1, 1'b0, 3'd0, 8'h00);
    wait_finish(0, lat, seen);
    check("b2b2_first_out", var_table_output, 8'h11);
    var_table_address = 3'd1;
    wait_finish(0, n, seen);
    mem_request = 1'b0;
    check("b2b2_spacing", n, 3);
    check("b2b2_second_out", var_table_output, 8'h22);
    check("b2b2_second_rw", reg_write, 1);

    // Back-to-back reads, read_latency=1
    run_cmd(1, 1'b0, 1'b1, 3'd0, 8'h33, lat, seen);
    check("lat1_write_lat", lat, 1);
    run_cmd(1, 1'b0, 1'b1, 3'd1, 8'h44, lat, seen);
    issue(1, 1'b1, 1'b0, 3'd0, 8'h00);
    wait_finish(1, lat, seen);
    check("b2b1_first_lat", lat, 1);
    check("b2b1_first_out", var_table_output1, 8'h33);
    var_table_address = 3'd1;
    wait_finish(1, n, seen);
    mem_request1 = 1'b0;
    check("b2b1_spacing", n, 2);
    check("b2b1_second_out", var_table_output1, 8'h44);
    check("b2b1_second_rw", reg_write1, 1);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
